// File: rtl/temperature_abnormality_detector.sv
// Purpose : body temperature = base + coef * sensor, flagged when outside [LOW_LIMIT, HIGH_LIMIT].
// Latency : 2 cycles (sum register, then result register); one sample per cycle.
// Backpres: none; every sampleValid=1 cycle is accepted, resultValid pulses once per result.
//
// Ports:
//   clk, rst_n             - clock (rising edge), asynchronous active-low reset
//   sampleValid            - qualifies factoryBaseTemp / factoryTempCoef / tempSensorValue
//   temperature            - 9-bit computed temperature (held between results)
//   tempTooLow/tempTooHigh - result below / above the normal band (held)
//   temperatureAbnormality - alarm (held)
//   resultValid            - one-cycle pulse when the outputs carry a new result
//
// Optional feature macro: ABNORMAL_PERSIST_EN
//   Defined   : alarm only after PERSIST_COUNT consecutive out-of-band results.
//   Undefined : alarm = tempTooLow | tempTooHigh of the same result.
module temperature_abnormality_detector #(
  parameter logic [8:0] LOW_LIMIT     = 9'd35,
  parameter logic [8:0] HIGH_LIMIT    = 9'd39,
  parameter int         PERSIST_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sampleValid,
  input  logic [7:0] factoryBaseTemp,
  input  logic [3:0] factoryTempCoef,
  input  logic [3:0] tempSensorValue,
  output logic [8:0] temperature,
  output logic       tempTooLow,
  output logic       tempTooHigh,
  output logic       temperatureAbnormality,
  output logic       resultValid
);

  if (PERSIST_COUNT < 1 || PERSIST_COUNT > 15) begin : g_bad_persist
    $error("PERSIST_COUNT must be within 1..15");
  end

  // Widths chosen so nothing wraps: 15*15 = 225 fits 8 bits, 255 + 225 = 480 fits 9 bits.
  logic [7:0] w_product;
  logic [8:0] w_sum;
  assign w_product = 8'(factoryTempCoef) * 8'(tempSensorValue);
  assign w_sum     = 9'(factoryBaseTemp) + 9'(w_product);

  // Stage 1: sum register plus its valid bit. The sum holds when no sample arrives.
  logic [8:0] r_sum;
  logic       r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= sampleValid;
      if (sampleValid) begin
        r_sum <= w_sum;
      end
    end
  end

  // Band classification of the stage-1 sum; the limits themselves are normal.
  logic w_low;
  logic w_high;
  logic w_alarm;
  assign w_low  = (r_sum < LOW_LIMIT);
  assign w_high = (r_sum > HIGH_LIMIT);

`ifdef ABNORMAL_PERSIST_EN
  localparam logic [3:0] LP_PERSIST = 4'(PERSIST_COUNT);

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  // Streak counter: saturates at the threshold, any in-band result restarts it.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!(w_low || w_high)) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != LP_PERSIST) begin
      w_cnt_nxt = r_cnt + 4'd1;
    end
  end

  assign w_alarm = (w_cnt_nxt == LP_PERSIST);

  // Only real results move the counter, so idle gaps do not break a streak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_vld) begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_alarm = w_low | w_high;
`endif

  // Stage 2: result registers, loaded only when stage 1 holds a fresh sum.
  logic [8:0] r_temp;
  logic       r_low;
  logic       r_high;
  logic       r_alarm;
  logic       r_res_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp    <= '0;
      r_low     <= 1'b0;
      r_high    <= 1'b0;
      r_alarm   <= 1'b0;
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= r_vld;
      if (r_vld) begin
        r_temp  <= r_sum;
        r_low   <= w_low;
        r_high  <= w_high;
        r_alarm <= w_alarm;
      end
    end
  end

  assign temperature            = r_temp;
  assign tempTooLow             = r_low;
  assign tempTooHigh            = r_high;
  assign temperatureAbnormality = r_alarm;
  assign resultValid            = r_res_vld;

endmodule

// File: tb/tb_temperature_abnormality_detector.sv
// Purpose : self-checking bench for temperature_abnormality_detector (table vectors + scoreboard).
// Latency : expects each accepted sample's result on the second clock edge after acceptance.
// Backpres: none in the DUT; every driven sample is pushed to the scoreboard at drive time.
module tb_temperature_abnormality_detector;

  typedef struct {
    logic [7:0] base;
    logic [3:0] coef;
    logic [3:0] sensor;
    logic [8:0] exp_temp;
    logic       exp_low;
    logic       exp_high;
  } vec_t;

  typedef struct {
    logic [8:0] temp;
    logic       low;
    logic       high;
    logic       alarm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sampleValid = 1'b0;
  logic [7:0] factoryBaseTemp = '0;
  logic [3:0] factoryTempCoef = '0;
  logic [3:0] tempSensorValue = '0;
  logic [8:0] temperature;
  logic       tempTooLow;
  logic       tempTooHigh;
  logic       temperatureAbnormality;
  logic       resultValid;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t last_exp;
  int   m_cnt = 0;
  vec_t vecs[10];

  temperature_abnormality_detector dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .sampleValid            (sampleValid),
    .factoryBaseTemp        (factoryBaseTemp),
    .factoryTempCoef        (factoryTempCoef),
    .tempSensorValue        (tempSensorValue),
    .temperature            (temperature),
    .tempTooLow             (tempTooLow),
    .tempTooHigh            (tempTooHigh),
    .temperatureAbnormality (temperatureAbnormality),
    .resultValid            (resultValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference alarm: same-result flags by default, 3-in-a-row streak with the feature on.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.temp = v.exp_temp;
    e.low  = v.exp_low;
    e.high = v.exp_high;
`ifdef ABNORMAL_PERSIST_EN
    if (v.exp_low || v.exp_high) begin
      if (m_cnt < 3) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    e.alarm = (m_cnt == 3);
`else
    e.alarm = v.exp_low | v.exp_high;
`endif
    return e;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    sampleValid     = 1'b1;
    factoryBaseTemp = v.base;
    factoryTempCoef = v.coef;
    tempSensorValue = v.sensor;
    sb.push_back(model(v));
  endtask

  task automatic idle();
    @(negedge clk);
    sampleValid     = 1'b0;
    factoryBaseTemp = 8'hA5;
    factoryTempCoef = 4'hF;
    tempSensorValue = 4'hF;
  endtask

  function automatic vec_t mk(input int b, input int c, input int s, input int t, input int lo, input int hi);
    vec_t v;
    v.base = 8'(b); v.coef = 4'(c); v.sensor = 4'(s);
    v.exp_temp = 9'(t); v.exp_low = 1'(lo); v.exp_high = 1'(hi);
    return v;
  endfunction

  // Scoreboard monitor: every resultValid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && resultValid) begin
      chk("result_pending", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        last_exp = e;
        chk("temperature", int'(temperature), int'(e.temp));
        chk("tempTooLow", int'(tempTooLow), int'(e.low));
        chk("tempTooHigh", int'(tempTooHigh), int'(e.high));
        chk("alarm", int'(temperatureAbnormality), int'(e.alarm));
      end
      chk("flags_exclusive", int'(tempTooLow & tempTooHigh), 0);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_temperature"}, int'(temperature), 0);
    chk({tag, "_tooLow"}, int'(tempTooLow), 0);
    chk({tag, "_tooHigh"}, int'(tempTooHigh), 0);
    chk({tag, "_alarm"}, int'(temperatureAbnormality), 0);
    chk({tag, "_resultValid"}, int'(resultValid), 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    vecs[0] = mk( 17,  8,  2,  33, 1, 0);
    vecs[1] = mk( 35,  0,  0,  35, 0, 0);
    vecs[2] = mk( 39,  0,  5,  39, 0, 0);
    vecs[3] = mk( 34,  0,  0,  34, 1, 0);
    vecs[4] = mk( 40,  0,  0,  40, 0, 1);
    vecs[5] = mk(255, 15, 15, 480, 0, 1);
    vecs[6] = mk( 20, 15,  1,  35, 0, 0);
    vecs[7] = mk(  0,  0,  0,   0, 1, 0);
    vecs[8] = mk( 10,  5,  5,  35, 0, 0);
    vecs[9] = mk( 15,  5,  5,  40, 0, 1);

    // Reset state while rst_n is held low.
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Single sample: resultValid after two edges, exactly one cycle wide.
    drive(vecs[0]);
    idle();
    chk("pulse_early", int'(resultValid), 0);
    idle();
    chk("pulse_on", int'(resultValid), 1);
    idle();
    chk("pulse_off", int'(resultValid), 0);

    // Back-to-back stream over the remaining table, then outputs must hold.
    for (int i = 1; i < 10; i++) drive(vecs[i]);
    idle();
    drain("stream");
    repeat (3) idle();
    chk("hold_resultValid", int'(resultValid), 0);
    chk("hold_temperature", int'(temperature), int'(last_exp.temp));
    chk("hold_tooHigh", int'(tempTooHigh), int'(last_exp.high));
    chk("hold_alarm", int'(temperatureAbnormality), int'(last_exp.alarm));

    // Streak pattern 33,33,33,37,33 after an in-band result.
    drive(mk(37, 0, 0, 37, 0, 0));
    drive(mk(33, 0, 0, 33, 1, 0));
    drive(mk(33, 0, 0, 33, 1, 0));
    drive(mk(33, 0, 0, 33, 1, 0));
    drive(mk(37, 0, 0, 37, 0, 0));
    drive(mk(33, 0, 0, 33, 1, 0));
    idle();
    drain("streak");

    // Idle gaps between abnormal samples keep the streak alive.
    drive(mk(37, 0, 0, 37, 0, 0));
    drive(mk(33, 0, 0, 33, 1, 0));
    idle();
    drive(mk(41, 0, 0, 41, 0, 1));
    idle();
    idle();
    drive(mk(30, 0, 0, 30, 1, 0));
    drive(mk(36, 0, 0, 36, 0, 0));
    idle();
    drain("gap");

    // Asynchronous reset mid-stream: outputs clear at once, in-flight samples vanish.
    drive(mk(40, 1, 1, 41, 0, 1));
    drive(mk(20, 1, 1, 21, 1, 0));
    drive(mk(50, 1, 1, 51, 0, 1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sampleValid = 1'b0;
    #1;
    chk_zero("midreset");
    sb.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle();
    chk("post_reset_resultValid", int'(resultValid), 0);
    chk("post_reset_temperature", int'(temperature), 0);

    // Pipeline still works after reset release.
    drive(vecs[5]);
    idle();
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
